// File: rtl/aes_stim_harness.sv
// aes_stim_harness
//
// Stimulus generator and result capture wrapped around an external AES core.
// Two DATA_W registers (state and key) are advanced on request, either by a
// fixed increment or by a Galois LFSR step. Every advance sends a token down
// a delay line that tracks the core latency. When the token comes out, the
// folded core result captured on that cycle is flagged with out_valid.
//
// Build option:
//   AES_STIM_LFSR_EN  when defined, the LFSR datapath is built and `mode`
//                     selects between increment (0) and LFSR (1). When it is
//                     undefined, `mode` is ignored and only increment exists.
//
// Parameters:
//   DATA_W    state/key/core bus width
//   OUT_W     folded output width (1..DATA_W, must divide DATA_W)
//   CORE_LAT  external core latency in cycles (1..63)
//   STEP      increment-mode addend
//   POLY      Galois LFSR tap mask
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   state_change  advance the state register this edge
//   key_change    advance the key register this edge
//   mode          0 = increment, 1 = LFSR (LFSR builds only)
//   core_state    state register, to the core
//   core_key      key register, to the core
//   core_out      core result
//   out           registered fold of core_out
//   out_valid     one-cycle pulse on the out sample that belongs to an advance
//   sample_cnt    saturating count of out_valid pulses

module aes_stim_harness #(
   parameter int                DATA_W   = 128,
   parameter int                OUT_W    = 1,
   parameter int                CORE_LAT = 20,
   parameter logic [DATA_W-1:0] STEP     = DATA_W'(1),
   parameter logic [DATA_W-1:0] POLY     = DATA_W'(128'h87)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              state_change,
   input  logic              key_change,
   input  logic              mode,
   output logic [DATA_W-1:0] core_state,
   output logic [DATA_W-1:0] core_key,
   input  logic [DATA_W-1:0] core_out,
   output logic [OUT_W-1:0]  out,
   output logic              out_valid,
   output logic [15:0]       sample_cnt
);

   logic [DATA_W-1:0]   state_q;
   logic [DATA_W-1:0]   key_q;
   logic [DATA_W-1:0]   state_nxt;
   logic [DATA_W-1:0]   key_nxt;
   logic [CORE_LAT-1:0] tok_q;
   logic                tok_core_q;
   logic [OUT_W-1:0]    fold_d;
   logic [OUT_W-1:0]    out_q;
   logic                out_valid_q;
   logic [15:0]         cnt_q;
   logic                advance;

   // A simultaneous state+key request is one advance and issues one token.
   assign advance = state_change | key_change;

`ifdef AES_STIM_LFSR_EN
   // Galois step (right shift, taps folded in when the dropped bit is 1).
   // All-zero is a fixed point of this recurrence, so it is kicked to 1.
   function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] x);
      logic [DATA_W-1:0] r;
      if (x == '0) begin
         r = DATA_W'(1);
      end else begin
         r = (x >> 1) ^ (x[0] ? POLY : '0);
      end
      return r;
   endfunction

   always_comb begin
      state_nxt = state_q + STEP;
      key_nxt   = key_q + STEP;
      if (mode) begin
         state_nxt = lfsr_next(state_q);
         key_nxt   = lfsr_next(key_q);
      end
   end
`else
   logic              mode_unused;
   logic [DATA_W-1:0] poly_unused;

   assign mode_unused = mode;
   assign poly_unused = POLY;

   always_comb begin
      state_nxt = state_q + STEP;
      key_nxt   = key_q + STEP;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= '0;
         key_q   <= '0;
      end else begin
         if (state_change) begin
            state_q <= state_nxt;
         end
         if (key_change) begin
            key_q <= key_nxt;
         end
      end
   end

   // Interleaved fold: output bit i collects every core_out bit j with
   // j mod OUT_W == i. With OUT_W = 1 this is a plain XOR-reduce.
   always_comb begin
      fold_d = '0;
      for (int j = 0; j < DATA_W; j++) begin
         fold_d[j % OUT_W] = fold_d[j % OUT_W] ^ core_out[j];
      end
   end

   // Token timing: the core result for an advance sampled at edge E shows up
   // on core_out after edge E+CORE_LAT. The delay line covers E..E+CORE_LAT-1,
   // tok_core_q lines up with the core result, and out_valid lines up with
   // out, which captures that result one edge later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tok_q       <= '0;
         tok_core_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         tok_q[0] <= advance;
         for (int i = 1; i < CORE_LAT; i++) begin
            tok_q[i] <= tok_q[i-1];
         end
         tok_core_q  <= tok_q[CORE_LAT-1];
         out_valid_q <= tok_core_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
      end else begin
         out_q <= fold_d;
      end
   end

   // Counted on the same edge that raises out_valid, so the count already
   // includes a pulse while that pulse is visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (tok_core_q && (cnt_q != 16'hFFFF)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign core_state = state_q;
   assign core_key   = key_q;
   assign out        = out_q;
   assign out_valid  = out_valid_q;
   assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_aes_stim_harness.sv
module tb_aes_stim_harness;

   localparam int LAT_A = 20;
   localparam int LAT_B = 3;

`ifdef AES_STIM_LFSR_EN
   localparam bit LFSR_EN = 1'b1;
`else
   localparam bit LFSR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;

   logic         sc_a, kc_a, mode_a;
   logic [127:0] cs_a, ck_a, co_a;
   logic         out_a, ov_a;
   logic [15:0]  cnt_a;

   logic         sc_b, kc_b, mode_b;
   logic [7:0]   cs_b, ck_b, co_b;
   logic [3:0]   out_b;
   logic         ov_b;
   logic [15:0]  cnt_b;

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           exp_q[$];
   logic [127:0] st_m, ky_m;
   logic [15:0]  cnt_before;

   typedef struct {
      logic [127:0] co_a;
      logic         exp_a;
      logic [7:0]   co_b;
      logic [3:0]   exp_b;
   } fold_vec_t;

   fold_vec_t fv[7];

   aes_stim_harness #(
      .DATA_W(128), .OUT_W(1), .CORE_LAT(LAT_A)
   ) dut_a (
      .clk(clk), .rst(rst),
      .state_change(sc_a), .key_change(kc_a), .mode(mode_a),
      .core_state(cs_a), .core_key(ck_a), .core_out(co_a),
      .out(out_a), .out_valid(ov_a), .sample_cnt(cnt_a)
   );

   aes_stim_harness #(
      .DATA_W(8), .OUT_W(4), .CORE_LAT(LAT_B),
      .STEP(8'h01), .POLY(8'h87)
   ) dut_b (
      .clk(clk), .rst(rst),
      .state_change(sc_b), .key_change(kc_b), .mode(mode_b),
      .core_state(cs_b), .core_key(ck_b), .core_out(co_b),
      .out(out_b), .out_valid(ov_b), .sample_cnt(cnt_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] nxt_m(input logic [127:0] x, input logic m);
      if (m && LFSR_EN) begin
         if (x == 128'h0) return 128'h1;
         return {1'b0, x[127:1]} ^ (x[0] ? 128'h87 : 128'h0);
      end
      return x + 128'h1;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic adv_a(input logic s, input logic k, input int n);
      for (int i = 0; i < n; i++) begin
         sc_a = s;
         kc_a = k;
         if (s | k) exp_q.push_back(cyc + LAT_A + 2);
         if (s) st_m = nxt_m(st_m, mode_a);
         if (k) ky_m = nxt_m(ky_m, mode_a);
         step();
      end
      sc_a = 1'b0;
      kc_a = 1'b0;
   endtask

   // Scoreboard: each advance queued the edge number its pulse must land on.
   always @(negedge clk) begin : mon
      int e;
      if (!rst) begin
         if (ov_a) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pulse_unexpected: out_valid at edge %0d, none expected", cyc);
            end else begin
               e = exp_q.pop_front();
               if (e != cyc) begin
                  errors++;
                  $display("FAIL pulse_timing: out_valid at edge %0d, expected edge %0d", cyc, e);
               end
            end
         end else if (exp_q.size() > 0 && exp_q[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL pulse_missing: no out_valid at edge %0d (now %0d)", exp_q[0], cyc);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      fv[0] = '{128'h1, 1'b1, 8'h01, 4'b0001};
      fv[1] = '{128'h11, 1'b0, 8'h11, 4'b0000};
      fv[2] = '{128'h3, 1'b0, 8'h12, 4'b0011};
      fv[3] = '{128'h8000_0000_0000_0000_0000_0000_0000_0001, 1'b0, 8'hF0, 4'b1111};
      fv[4] = '{128'h7, 1'b1, 8'h80, 4'b1000};
      fv[5] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b1, 8'h5A, 4'b1111};
      fv[6] = '{{128{1'b1}}, 1'b0, 8'h36, 4'b0101};

      rst = 1'b1;
      sc_a = 1'b0; kc_a = 1'b0; mode_a = 1'b0; co_a = 128'h1;
      sc_b = 1'b0; kc_b = 1'b0; mode_b = 1'b0; co_b = 8'h01;
      st_m = '0; ky_m = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", cs_a, 128'h0);
      chk("rst_key", ck_a, 128'h0);
      chk("rst_out", out_a, 1'b0);
      chk("rst_out_valid", ov_a, 1'b0);
      chk("rst_sample_cnt", cnt_a, 16'h0);
      chk("rst_out_b", out_b, 4'h0);

      // First edge after release must already take the advance.
      @(negedge clk);
      rst = 1'b0;
      adv_a(1'b1, 1'b0, 3);
      chk("inc3_state", cs_a, 128'h3);
      chk("inc3_key", ck_a, 128'h0);
      repeat (LAT_A + 3) step();
      chk("inc3_sample_cnt", cnt_a, 16'd3);

      for (int i = 0; i < 7; i++) begin
         co_a = fv[i].co_a;
         co_b = fv[i].co_b;
         step();
         chk($sformatf("fold_a[%0d]", i), out_a, fv[i].exp_a);
         chk($sformatf("fold_b[%0d]", i), out_b, fv[i].exp_b);
      end

      // LFSR (or, without the option, increment regardless of mode) on key.
      mode_a = 1'b1;
      adv_a(1'b0, 1'b1, 1);
      chk("mode1_key_from0", ck_a, 128'h1);
      adv_a(1'b0, 1'b1, 1);
      chk("mode1_key_from1", ck_a, LFSR_EN ? 128'h87 : 128'h2);
      chk("mode1_state_held", cs_a, 128'h3);
      mode_a = 1'b0;
      step();
      chk("mode_switch_key_held", ck_a, ky_m);
      adv_a(1'b0, 1'b1, 1);
      chk("mode0_key_inc", ck_a, ky_m);
      repeat (LAT_A + 3) step();

      cnt_before = cnt_a;
      adv_a(1'b1, 1'b1, 1);
      chk("both_state", cs_a, st_m);
      chk("both_key", ck_a, ky_m);
      repeat (LAT_A + 3) step();
      chk("both_one_pulse", cnt_a, cnt_before + 16'd1);

      // Reset mid-cycle with five tokens in flight.
      co_a = 128'h1;
      adv_a(1'b1, 1'b0, 5);
      step();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_state", cs_a, 128'h0);
      chk("midrst_key", ck_a, 128'h0);
      chk("midrst_out", out_a, 1'b0);
      chk("midrst_out_valid", ov_a, 1'b0);
      chk("midrst_sample_cnt", cnt_a, 16'h0);
      exp_q.delete();
      st_m = '0;
      ky_m = '0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2 * LAT_A) step();
      chk("postrst_no_pulses", cnt_a, 16'h0);

      // Wrap on the narrow instance: 255 increments to all-ones, then 0.
      sc_b = 1'b1;
      repeat (255) step();
      chk("b_all_ones", cs_b, 8'hFF);
      step();
      sc_b = 1'b0;
      chk("b_wrap_zero", cs_b, 8'h00);
      chk("b_key_held", ck_b, 8'h00);
      repeat (LAT_B + 3) step();
      chk("b_sample_cnt", cnt_b, 16'd256);

      chk("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
